serv_csr_seq: RTL and testbench
===============================

Name: serv_csr_seq

Overview:
- Word-level front end for the bit-serial machine-CSR datapath (mstatus, mie, mcause).
- Accepts whole-word CSR access requests from two requesters: port A (core-side, e.g. a non-serial control unit) and port B (debug).
- Arbitrates round-robin between them, then serializes each granted access into N=32/W beats. It drives the CSR datapath's enable, beat strobes, register selects and source controls, and deserializes the returned old value.

Parameters:
- W, 1, datapath beat width; legal values 1 and 4.
- B, W-1, MSB index of beat-wide buses.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_a_req  in  1  port A request; held until o_a_ack.
- i_a_sel  in  2  port A register: 0 mstatus, 1 mie, 2 mcause, 3 reserved.
- i_a_op  in  2  port A op: 0 read, 1 write, 2 set, 3 clear.
- i_a_wdata  in  32  port A operand.
- o_a_ack  out  1  port A completion pulse.
- o_a_err  out  1  port A reserved-select error, valid with ack.
- o_a_rdata  out  32  port A old CSR value, valid with ack.
- i_b_req, i_b_sel, i_b_op, i_b_wdata, o_b_ack, o_b_err, o_b_rdata: same as port A, for port B.
- o_busy  out  1  transaction in progress.
- o_en  out  1  beat enable to CSR datapath.
- o_cnt0to3  out  1  beat strobe: current beat covers any of bits 0-3.
- o_cnt3, o_cnt7, o_cnt11, o_cnt12  out  1 each  beat strobe: current beat covers that bit.
- o_cnt_done  out  1  last beat.
- o_mstatus_en, o_mie_en, o_mcause_en  out  1 each  one-hot register select, high only during beats.
- o_csr_source  out  2  equals latched op (0 CSR, 1 EXT, 2 SET, 3 CLR).
- o_csr_d_sel  out  1  tied 0; operand is supplied on o_rs1.
- o_rs1  out  W  serialized operand, LSB first.
- i_q  in  W  CSR datapath read output for the current beat.

Behaviour:
- Reset (async, i_rst_n low): state IDLE, all outputs 0, round-robin pointer = A preferred, shift registers 0. Effective immediately, also mid-transaction. No ack is issued for an aborted transaction. After release, pending requests are re-arbitrated.
- States: IDLE, SHIFT, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Any request: grant the preferred requester if it requests, else the other one. Latch sel, op and wdata into local registers; later changes to request inputs are ignored.
  - Valid sel: go to SHIFT, beat counter = 0.
  - sel==3: go directly to ACK with err=1, rdata=0, no beats.
- SHIFT, for exactly N=32/W cycles:
  - o_en=1; the one-hot select for the latched sel is high; o_csr_source = latched op.
  - o_rs1 = low W bits of the operand shift register, which shifts right by W each beat.
  - The read shift register shifts right by W, inserting i_q at bits [31:32-W]. After N beats it holds the pre-modification CSR value.
  - Strobes are decoded from beat index k, which covers bits [kW, kW+W-1]:
    - W=1: cnt0to3 for k=0..3; cnt3 at k=3, cnt7 at k=7, cnt11 at k=11, cnt12 at k=12.
    - W=4: cnt0to3 and cnt3 at k=0; cnt7 at k=1; cnt11 at k=2; cnt12 at k=3.
  - o_cnt_done at k=N-1; then go to ACK.
- ACK, one cycle:
  - Granted port's ack=1, with rdata and err valid in the same cycle. o_en and all selects are 0.
  - The round-robin pointer flips to prefer the non-granted port.
  - Next state is IDLE.
- Timing: if request is sampled at edge E0, beats occupy cycles E1..EN, ack is in cycle EN+1, and the next grant is sampled at edge EN+2. Minimum request-to-request period is N+2 cycles.
- o_busy=1 in SHIFT and ACK.
- rdata/err registers hold their value after ack until the next ack on that port.
- A requester that deasserts req before ack gets protocol-undefined behaviour. The block still completes the latched transaction and pulses ack.
- Simultaneous A and B requests: the pointer decides. Alternation is guaranteed under continuous contention.

Decomposition:
- Shared package serv_csr_seq_pkg: sel encodings (SEL_MSTATUS=0, SEL_MIE=1, SEL_MCAUSE=2, SEL_RSVD=3), op encodings equal to the CSR source encodings, and state encoding (IDLE, SHIFT, ACK).
- Sub-module serv_csr_seq_arb: 2-way round-robin arbiter with inputs req[1:0] and update strobe, and a one-hot grant[1:0] output.
- Top level holds the FSM, beat counter, strobe decode and shift registers.

Test Plan:
- W=1, A read mie, CSR model returns mie=0x80: o_en high 32 cycles, o_mie_en only, o_csr_source=0, o_cnt7 at beat 7 only -> o_a_ack in cycle 33, o_a_rdata=0x00000080, err=0.
- W=1, B write mstatus 0x00000008: o_rs1 bit stream has a 1 only at beat 3, o_csr_source=1 -> o_b_ack after 32 beats, model mstatus.MIE=1.
- A and B both request continuously: grants alternate A,B,A,B, each ack separated by 34 cycles, never two acks in the same cycle.
- A sel=3: no o_en, ack with err=1 and rdata=0 on the cycle after sampling; next request served normally.
- i_rst_n asserted at beat 10 of a write: outputs zero immediately, no ack, model register unchanged beyond beats already done; after release, a held request restarts from beat 0.
- W=4, A set mcause 0x3: 8 beats, cnt0to3 and cnt3 at k=0, cnt_done at k=7 -> ack cycle 9, rdata = prior mcause.

Source files
------------

// File: rtl/serv_csr_seq_pkg.sv
// serv_csr_seq shared encodings.
// Selects, ops (equal to CSR source codes) and FSM states.
package serv_csr_seq_pkg;

  localparam logic [1:0] SEL_MSTATUS = 2'd0;
  localparam logic [1:0] SEL_MIE     = 2'd1;
  localparam logic [1:0] SEL_MCAUSE  = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLR   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/serv_csr_seq_arb.sv
// Two-way round-robin arbiter.
// On update the pointer moves to prefer the non-granted side.
module serv_csr_seq_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant[0] = req[0] & (~ptr | ~req[1]);
    grant[1] = req[1] & (ptr | ~req[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/serv_csr_seq.sv
// Word-level CSR front end: arbitrates two requesters and
// serializes each access into 32/W beats for the serial CSR datapath.
module serv_csr_seq
  import serv_csr_seq_pkg::*;
#(
  parameter int W = 1,
  parameter int B = W - 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_req,
  input  logic [1:0]  i_a_sel,
  input  logic [1:0]  i_a_op,
  input  logic [31:0] i_a_wdata,
  output logic        o_a_ack,
  output logic        o_a_err,
  output logic [31:0] o_a_rdata,
  input  logic        i_b_req,
  input  logic [1:0]  i_b_sel,
  input  logic [1:0]  i_b_op,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_ack,
  output logic        o_b_err,
  output logic [31:0] o_b_rdata,
  output logic        o_busy,
  output logic        o_en,
  output logic        o_cnt0to3,
  output logic        o_cnt3,
  output logic        o_cnt7,
  output logic        o_cnt11,
  output logic        o_cnt12,
  output logic        o_cnt_done,
  output logic        o_mstatus_en,
  output logic        o_mie_en,
  output logic        o_mcause_en,
  output logic [1:0]  o_csr_source,
  output logic        o_csr_d_sel,
  output logic [B:0]  o_rs1,
  input  logic [B:0]  i_q
);

  localparam int N = 32 / W;
  localparam logic [4:0] LAST = 5'(N - 1);
  localparam logic [4:0] K3   = 5'(3 / W);
  localparam logic [4:0] K7   = 5'(7 / W);
  localparam logic [4:0] K11  = 5'(11 / W);
  localparam logic [4:0] K12  = 5'(12 / W);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic        owner;
  logic [1:0]  sel;
  logic [1:0]  op;
  logic [31:0] wsh;
  logic [31:0] rsh;
  logic [31:0] rnew;
  logic [1:0]  arb_req;
  logic [1:0]  grant;
  logic        start;
  logic        last;
  logic [1:0]  req_sel;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;

  // Outside IDLE the arbiter sees the owner, so update flips correctly
  assign arb_req   = (state == IDLE) ? {i_b_req, i_a_req}
                                     : {owner, ~owner};
  assign start     = (state == IDLE) & (|grant);
  assign last      = (cnt == LAST);
  assign req_sel   = grant[1] ? i_b_sel : i_a_sel;
  assign req_op    = grant[1] ? i_b_op : i_a_op;
  assign req_wdata = grant[1] ? i_b_wdata : i_a_wdata;
  assign rnew      = {i_q, rsh[31:W]};

  serv_csr_seq_arb u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .req    (arb_req),
    .update (state == ACK),
    .grant  (grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (req_sel == SEL_RSVD) ? ACK : SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_en         = (state == SHIFT);
    o_busy       = (state != IDLE);
    o_a_ack      = (state == ACK) & ~owner;
    o_b_ack      = (state == ACK) & owner;
    o_cnt0to3    = o_en & (cnt <= K3);
    o_cnt3       = o_en & (cnt == K3);
    o_cnt7       = o_en & (cnt == K7);
    o_cnt11      = o_en & (cnt == K11);
    o_cnt12      = o_en & (cnt == K12);
    o_cnt_done   = o_en & last;
    o_mstatus_en = o_en & (sel == SEL_MSTATUS);
    o_mie_en     = o_en & (sel == SEL_MIE);
    o_mcause_en  = o_en & (sel == SEL_MCAUSE);
    o_csr_source = op;
    o_csr_d_sel  = 1'b0;
    o_rs1        = o_en ? wsh[B:0] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      owner     <= 1'b0;
      sel       <= '0;
      op        <= '0;
      wsh       <= '0;
      rsh       <= '0;
      o_a_rdata <= '0;
      o_a_err   <= 1'b0;
      o_b_rdata <= '0;
      o_b_err   <= 1'b0;
    end else begin
      if (start) begin
        owner <= grant[1];
        sel   <= req_sel;
        op    <= req_op;
        wsh   <= req_wdata;
        cnt   <= '0;
        if (req_sel == SEL_RSVD) begin
          if (grant[1]) begin
            o_b_rdata <= '0;
            o_b_err   <= 1'b1;
          end else begin
            o_a_rdata <= '0;
            o_a_err   <= 1'b1;
          end
        end
      end
      if (state == SHIFT) begin
        cnt <= cnt + 5'd1;
        wsh <= wsh >> W;
        rsh <= rnew;
        if (last) begin
          if (owner) begin
            o_b_rdata <= rnew;
            o_b_err   <= 1'b0;
          end else begin
            o_a_rdata <= rnew;
            o_a_err   <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_csr_seq.sv
// Directed bench for serv_csr_seq: W=1 and W=4 instances,
// each driving a small bit-serial CSR register model.
module tb_serv_csr_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_req, b_req;
  logic [1:0]  a_sel, a_op, b_sel, b_op;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        busy, en, c0, c3, c7, c11, c12, cdone;
  logic        ms_en, mie_en, mc_en, d_sel;
  logic [1:0]  src;
  logic        rs1, q;

  logic        a4_req, b4_req;
  logic [1:0]  a4_sel, a4_op, b4_sel, b4_op;
  logic [31:0] a4_wdata, b4_wdata;
  logic        a4_ack, a4_err, b4_ack, b4_err;
  logic [31:0] a4_rdata, b4_rdata;
  logic        busy4, en4, c04, c34, c74, c114, c124, cdone4;
  logic        ms4_en, mie4_en, mc4_en, d_sel4;
  logic [1:0]  src4;
  logic [3:0]  rs1_4, q4;

  serv_csr_seq #(.W(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_sel(a_sel), .i_a_op(a_op),
    .i_a_wdata(a_wdata), .o_a_ack(a_ack), .o_a_err(a_err),
    .o_a_rdata(a_rdata),
    .i_b_req(b_req), .i_b_sel(b_sel), .i_b_op(b_op),
    .i_b_wdata(b_wdata), .o_b_ack(b_ack), .o_b_err(b_err),
    .o_b_rdata(b_rdata),
    .o_busy(busy), .o_en(en), .o_cnt0to3(c0), .o_cnt3(c3),
    .o_cnt7(c7), .o_cnt11(c11), .o_cnt12(c12),
    .o_cnt_done(cdone), .o_mstatus_en(ms_en),
    .o_mie_en(mie_en), .o_mcause_en(mc_en),
    .o_csr_source(src), .o_csr_d_sel(d_sel),
    .o_rs1(rs1), .i_q(q)
  );

  serv_csr_seq #(.W(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a4_req), .i_a_sel(a4_sel), .i_a_op(a4_op),
    .i_a_wdata(a4_wdata), .o_a_ack(a4_ack), .o_a_err(a4_err),
    .o_a_rdata(a4_rdata),
    .i_b_req(b4_req), .i_b_sel(b4_sel), .i_b_op(b4_op),
    .i_b_wdata(b4_wdata), .o_b_ack(b4_ack), .o_b_err(b4_err),
    .o_b_rdata(b4_rdata),
    .o_busy(busy4), .o_en(en4), .o_cnt0to3(c04), .o_cnt3(c34),
    .o_cnt7(c74), .o_cnt11(c114), .o_cnt12(c124),
    .o_cnt_done(cdone4), .o_mstatus_en(ms4_en),
    .o_mie_en(mie4_en), .o_mcause_en(mc4_en),
    .o_csr_source(src4), .o_csr_d_sel(d_sel4),
    .o_rs1(rs1_4), .i_q(q4)
  );

  function automatic logic [3:0] upd(input logic [1:0] s,
                                     input logic [3:0] qv,
                                     input logic [3:0] d);
    case (s)
      2'd0:    return qv;
      2'd1:    return d;
      2'd2:    return qv | d;
      default: return qv & ~d;
    endcase
  endfunction

  // Serial CSR models: registers are touched only on enabled beats
  logic [31:0] ms1 = '0, mie1 = '0, mc1 = '0;
  logic [4:0]  k1 = '0;
  logic [3:0]  n1;
  always_comb begin
    q  = mie_en ? mie1[k1] : mc_en ? mc1[k1] : ms1[k1];
    n1 = upd(src, {3'b000, q}, {3'b000, rs1});
  end
  always @(posedge clk) begin
    if (en) begin
      if (ms_en)  ms1[k1]  <= n1[0];
      if (mie_en) mie1[k1] <= n1[0];
      if (mc_en)  mc1[k1]  <= n1[0];
      k1 <= k1 + 5'd1;
    end else begin
      k1 <= '0;
    end
  end

  logic [31:0] ms4 = '0, mie4 = '0, mc4 = '0;
  logic [2:0]  k4 = '0;
  logic [3:0]  n4;
  always_comb begin
    q4 = mie4_en ? mie4[{k4, 2'b00} +: 4]
       : mc4_en  ? mc4[{k4, 2'b00} +: 4]
       : ms4[{k4, 2'b00} +: 4];
    n4 = upd(src4, q4, rs1_4);
  end
  always @(posedge clk) begin
    if (en4) begin
      if (ms4_en)  ms4[{k4, 2'b00} +: 4]  <= n4;
      if (mie4_en) mie4[{k4, 2'b00} +: 4] <= n4;
      if (mc4_en)  mc4[{k4, 2'b00} +: 4]  <= n4;
      k4 <= k4 + 3'd1;
    end else begin
      k4 <= '0;
    end
  end

  bit use4, use_b;
  logic        ob_ack, ob_err, ob_en, ob_c0, ob_c3, ob_c7;
  logic        ob_c11, ob_c12, ob_done;
  logic [31:0] ob_rdata;
  logic [1:0]  ob_src;
  logic [2:0]  ob_sels;
  logic [3:0]  ob_rs1;
  always_comb begin
    ob_ack   = use4 ? a4_ack : use_b ? b_ack : a_ack;
    ob_err   = use4 ? a4_err : use_b ? b_err : a_err;
    ob_rdata = use4 ? a4_rdata : use_b ? b_rdata : a_rdata;
    ob_en    = use4 ? en4 : en;
    ob_c0    = use4 ? c04 : c0;
    ob_c3    = use4 ? c34 : c3;
    ob_c7    = use4 ? c74 : c7;
    ob_c11   = use4 ? c114 : c11;
    ob_c12   = use4 ? c124 : c12;
    ob_done  = use4 ? cdone4 : cdone;
    ob_src   = use4 ? src4 : src;
    ob_sels  = use4 ? {mc4_en, mie4_en, ms4_en}
                    : {mc_en, mie_en, ms_en};
    ob_rs1   = use4 ? rs1_4 : {3'b000, rs1};
  end

  int          t_lat, t_beats, t_selbad, t_srcbad;
  logic [31:0] t_rd, t_rs1;
  logic        t_err;
  logic [63:0] m_c0, m_c3, m_c7, m_c11, m_c12, m_done;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input bit d4, input bit pb, input logic [1:0] s,
                     input logic [1:0] o, input logic [31:0] wd);
    int nb;
    logic [2:0] exps;
    use4 = d4;
    use_b = pb;
    nb = d4 ? 8 : 32;
    t_lat = 0; t_beats = 0; t_selbad = 0; t_srcbad = 0;
    t_rd = '0; t_err = 1'b0; t_rs1 = '0;
    m_c0 = '0; m_c3 = '0; m_c7 = '0;
    m_c11 = '0; m_c12 = '0; m_done = '0;
    exps = (s == 2'd0) ? 3'b001 : (s == 2'd1) ? 3'b010
         : (s == 2'd2) ? 3'b100 : 3'b000;
    if (d4) begin
      a4_sel = s; a4_op = o; a4_wdata = wd; a4_req = 1'b1;
    end else if (pb) begin
      b_sel = s; b_op = o; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_sel = s; a_op = o; a_wdata = wd; a_req = 1'b1;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ob_en) begin
        t_beats++;
        if (ob_src !== o) t_srcbad++;
        if (ob_sels !== exps) t_selbad++;
        if (i <= nb) begin
          if (d4) t_rs1[(i-1)*4 +: 4] = ob_rs1;
          else    t_rs1[i-1] = ob_rs1[0];
        end
      end else if (ob_sels !== 3'b000) begin
        t_selbad++;
      end
      if (ob_c0)   m_c0[i-1] = 1'b1;
      if (ob_c3)   m_c3[i-1] = 1'b1;
      if (ob_c7)   m_c7[i-1] = 1'b1;
      if (ob_c11)  m_c11[i-1] = 1'b1;
      if (ob_c12)  m_c12[i-1] = 1'b1;
      if (ob_done) m_done[i-1] = 1'b1;
      if (ob_ack) begin
        t_lat = i;
        t_rd = ob_rdata;
        t_err = ob_err;
        break;
      end
    end
    if (d4) a4_req = 1'b0;
    else if (pb) b_req = 1'b0;
    else a_req = 1'b0;
    @(negedge clk);
  endtask

  int nack, both;
  int tack [4];
  logic [3:0] pattern;

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_sel = 0; a_op = 0; a_wdata = 0;
    b_req = 0; b_sel = 0; b_op = 0; b_wdata = 0;
    a4_req = 0; a4_sel = 0; a4_op = 0; a4_wdata = 0;
    b4_req = 0; b4_sel = 0; b4_op = 0; b4_wdata = 0;
    use4 = 0; use_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_src", src, 0);
    chk("rst_cnt0to3", c0, 0);
    chk("rst_d_sel", d_sel, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A writes mie = 0x80, then reads it back
    txn(0, 0, 2'd1, 2'd1, 32'h0000_0080);
    chk("wr_mie_lat", t_lat, 33);
    chk("wr_mie_model", mie1, 32'h80);
    txn(0, 0, 2'd1, 2'd0, 32'h0);
    chk("rd_mie_lat", t_lat, 33);
    chk("rd_mie_beats", t_beats, 32);
    chk("rd_mie_sel", t_selbad, 0);
    chk("rd_mie_src", t_srcbad, 0);
    chk("rd_mie_c7", m_c7, 64'h80);
    chk("rd_mie_c0", m_c0, 64'hF);
    chk("rd_mie_c3", m_c3, 64'h8);
    chk("rd_mie_c11", m_c11, 64'h800);
    chk("rd_mie_c12", m_c12, 64'h1000);
    chk("rd_mie_done", m_done, 64'h8000_0000);
    chk("rd_mie_rdata", t_rd, 32'h80);
    chk("rd_mie_err", t_err, 0);

    // B writes mstatus.MIE
    txn(0, 1, 2'd0, 2'd1, 32'h0000_0008);
    chk("wr_ms_lat", t_lat, 33);
    chk("wr_ms_rs1", t_rs1, 32'h8);
    chk("wr_ms_src", t_srcbad, 0);
    chk("wr_ms_rdata", t_rd, 32'h0);
    chk("wr_ms_model", ms1, 32'h8);

    // Reserved select then a normal request
    txn(0, 0, 2'd3, 2'd1, 32'hDEAD_BEEF);
    chk("rsvd_lat", t_lat, 1);
    chk("rsvd_beats", t_beats, 0);
    chk("rsvd_err", t_err, 1);
    chk("rsvd_rdata", t_rd, 32'h0);
    chk("rsvd_sel", t_selbad, 0);
    txn(0, 0, 2'd0, 2'd0, 32'h0);
    chk("after_rsvd_lat", t_lat, 33);
    chk("after_rsvd_rdata", t_rd, 32'h8);
    chk("after_rsvd_err", t_err, 0);

    // Abort a B write of all-ones at beat 10
    use4 = 0; use_b = 1;
    b_sel = 2'd0; b_op = 2'd1; b_wdata = 32'hFFFF_FFFF; b_req = 1'b1;
    repeat (11) @(negedge clk);
    chk("abort_pre_en", en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_en", en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack", b_ack, 0);
    chk("abort_ms_en", ms_en, 0);
    chk("abort_rdata", b_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ack_late", b_ack, 0);
    chk("abort_model", ms1, 32'h3FF);
    rst_n = 1'b1;
    txn(0, 1, 2'd0, 2'd1, 32'hFFFF_FFFF);
    chk("restart_lat", t_lat, 33);
    chk("restart_rdata", t_rd, 32'h3FF);
    chk("restart_model", ms1, 32'hFFFF_FFFF);

    // Continuous contention from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    use4 = 0;
    a_sel = 2'd1; a_op = 2'd0; b_sel = 2'd2; b_op = 2'd0;
    a_req = 1'b1; b_req = 1'b1;
    nack = 0; both = 0; pattern = '0;
    for (int i = 0; i < 4; i++) tack[i] = 0;
    for (int i = 1; i <= 150 && nack < 4; i++) begin
      @(negedge clk);
      if (a_ack && b_ack) both++;
      if (a_ack || b_ack) begin
        pattern[nack] = b_ack;
        tack[nack] = i;
        nack++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_count", nack, 4);
    chk("rr_order", pattern, 4'b1010);
    chk("rr_first", tack[0], 33);
    chk("rr_gap1", tack[1] - tack[0], 34);
    chk("rr_gap2", tack[2] - tack[1], 34);
    chk("rr_gap3", tack[3] - tack[2], 34);
    chk("rr_both", both, 0);

    // W=4: write mcause, then set bits 1:0
    txn(1, 0, 2'd2, 2'd1, 32'h8000_0004);
    chk("w4_wr_lat", t_lat, 9);
    chk("w4_wr_model", mc4, 32'h8000_0004);
    txn(1, 0, 2'd2, 2'd2, 32'h0000_0003);
    chk("w4_set_lat", t_lat, 9);
    chk("w4_set_beats", t_beats, 8);
    chk("w4_set_c0", m_c0, 64'h1);
    chk("w4_set_c3", m_c3, 64'h1);
    chk("w4_set_c7", m_c7, 64'h2);
    chk("w4_set_c11", m_c11, 64'h4);
    chk("w4_set_c12", m_c12, 64'h8);
    chk("w4_set_done", m_done, 64'h80);
    chk("w4_set_rs1", t_rs1, 32'h3);
    chk("w4_set_src", t_srcbad, 0);
    chk("w4_set_sel", t_selbad, 0);
    chk("w4_set_rdata", t_rd, 32'h8000_0004);
    chk("w4_set_model", mc4, 32'h8000_0007);
    chk("w4_b_idle", {b4_ack, b4_err, busy4, d_sel4}, 0);
    chk("w4_b_rdata", b4_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
